// File: rtl/led_string_tx.sv
// One-wire LED string transmitter (WS2812B/SK6812 class): pixel FIFO feeding an MSB-first
// serialiser with cycle-exact bit timing and a latch (reset) low period on request.
module led_string_tx #(
  parameter int unsigned CLK_PERIOD_NS = 100,
  parameter int unsigned BPP           = 24,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned T0H_NS        = 400,
  parameter int unsigned T0L_NS        = 850,
  parameter int unsigned T1H_NS        = 800,
  parameter int unsigned T1L_NS        = 450,
  parameter int unsigned RESET_NS      = 80000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [BPP-1:0]             s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       latch,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       underrun,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       sdi
);

  function automatic int unsigned ns_to_cyc(input int unsigned ns);
    int unsigned c;
    c = (ns + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS;
    return (c == 0) ? 1 : c;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned T0HCyc   = ns_to_cyc(T0H_NS);
  localparam int unsigned T0LCyc   = ns_to_cyc(T0L_NS);
  localparam int unsigned T1HCyc   = ns_to_cyc(T1H_NS);
  localparam int unsigned T1LCyc   = ns_to_cyc(T1L_NS);
  localparam int unsigned ResetCyc = ns_to_cyc(RESET_NS);
  localparam int unsigned MaxCyc   = max2(max2(max2(T0HCyc, T0LCyc), max2(T1HCyc, T1LCyc)),
                                          ResetCyc);
  localparam int unsigned CntW     = $clog2(MaxCyc) + 1;
  localparam int unsigned PtrW     = $clog2(DEPTH);
  localparam int unsigned LvlW     = $clog2(DEPTH + 1);
  localparam int unsigned BitW     = $clog2(BPP);

  // Counters load "cycles - 1" and the phase ends on the cycle they read zero.
  localparam logic [CntW-1:0] T0HLd   = CntW'(T0HCyc - 1);
  localparam logic [CntW-1:0] T0LLd   = CntW'(T0LCyc - 1);
  localparam logic [CntW-1:0] T1HLd   = CntW'(T1HCyc - 1);
  localparam logic [CntW-1:0] T1LLd   = CntW'(T1LCyc - 1);
  localparam logic [CntW-1:0] ResetLd = CntW'(ResetCyc - 1);

  function automatic logic [CntW-1:0] hi_ld(input logic b);
    return b ? T1HLd : T0HLd;
  endfunction

  function automatic logic [CntW-1:0] lo_ld(input logic b);
    return b ? T1LLd : T0LLd;
  endfunction

  typedef enum logic [1:0] {StIdle, StHigh, StLow, StLatch} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [BitW-1:0] bit_q, bit_d;
  logic [BPP-1:0]  shift_q, shift_d;
  logic            pending_q, pending_d;
  logic            underrun_q, underrun_d;
  logic            sdi_q, sdi_d;

  logic [BPP-1:0]  mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic            push, pop, fifo_empty;
  logic [BPP-1:0]  head;

  always_comb begin : fifo_next
    push       = s_valid && s_ready;
    fifo_empty = (level_q == '0);
    head       = mem_q[rptr_q];
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    level_d    = level_q;
    if (push) wptr_d = wptr_q + PtrW'(1);
    if (pop)  rptr_d = rptr_q + PtrW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin : fsm_next
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    pending_d  = pending_q | latch;
    underrun_d = underrun_q;
    pop        = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = head;
          bit_d   = BitW'(BPP - 1);
          cnt_d   = hi_ld(head[BPP-1]);
          state_d = StHigh;
        end else if (pending_q) begin
          cnt_d   = ResetLd;
          state_d = StLatch;
        end
      end
      StHigh: begin
        if (cnt_q == '0) begin
          cnt_d   = lo_ld(shift_q[BPP-1]);
          state_d = StLow;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StLow: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else if (bit_q != '0) begin
          shift_d = shift_q << 1;
          bit_d   = bit_q - BitW'(1);
          cnt_d   = hi_ld(shift_q[BPP-2]);
          state_d = StHigh;
        end else if (!fifo_empty) begin
          // Back-to-back pixel: reload without passing through idle.
          pop     = 1'b1;
          shift_d = head;
          bit_d   = BitW'(BPP - 1);
          cnt_d   = hi_ld(head[BPP-1]);
          state_d = StHigh;
        end else begin
          state_d = StIdle;
          if (!pending_q) underrun_d = 1'b1;
        end
      end
      StLatch: begin
        if (cnt_q == '0) begin
          pending_d = 1'b0;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    sdi_d = (state_d == StHigh);
  end

  always_ff @(posedge clk) begin : state_regs
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      pending_q  <= 1'b0;
      underrun_q <= 1'b0;
      sdi_q      <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      pending_q  <= pending_d;
      underrun_q <= underrun_d;
      sdi_q      <= sdi_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
    end
  end

  always_ff @(posedge clk) begin : fifo_mem
    if (push) mem_q[wptr_q] <= s_data;
  end

  always_comb begin : outputs
    s_ready    = (level_q != LvlW'(DEPTH));
    busy       = (state_q != StIdle) || pending_q;
    frame_done = (state_q == StLatch) && (cnt_q == '0);
    underrun   = underrun_q;
    fifo_level = level_q;
    sdi        = sdi_q;
  end

endmodule

// File: tb/tb_led_string_tx.sv
// Bench for led_string_tx: random pixels are decoded back from sdi by pulse widths and
// compared with the pushed stream; FIFO level is modelled as pushes minus pixels started.
module tb_led_string_tx;

  localparam int ClkNs = 100;

  function automatic int to_cyc(input int ns);
    int c;
    c = (ns + ClkNs - 1) / ClkNs;
    return (c < 1) ? 1 : c;
  endfunction

  localparam int T0H  = to_cyc(400);
  localparam int T0L  = to_cyc(850);
  localparam int T1H  = to_cyc(800);
  localparam int T1L  = to_cyc(450);
  localparam int RstC = to_cyc(80000);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] a_data = '0;
  logic        a_valid = 1'b0, a_latch = 1'b0;
  logic        a_ready, a_busy, a_fd, a_ur, a_sdi;
  logic [2:0]  a_level;

  logic [31:0] b_data = '0;
  logic        b_valid = 1'b0, b_latch = 1'b0;
  logic        b_ready, b_busy, b_fd, b_ur, b_sdi;
  logic [2:0]  b_level;

  led_string_tx #(.CLK_PERIOD_NS(100), .BPP(24), .DEPTH(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .s_data(a_data), .s_valid(a_valid), .s_ready(a_ready),
    .latch(a_latch), .busy(a_busy), .frame_done(a_fd), .underrun(a_ur),
    .fifo_level(a_level), .sdi(a_sdi)
  );

  led_string_tx #(.CLK_PERIOD_NS(100), .BPP(32), .DEPTH(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .s_data(b_data), .s_valid(b_valid), .s_ready(b_ready),
    .latch(b_latch), .busy(b_busy), .frame_done(b_fd), .underrun(b_ur),
    .fifo_level(b_level), .sdi(b_sdi)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [23:0] exp_q[$];
  logic [23:0] rx_q[$];
  int          exp_level = 0, max_level = 0;
  int          cyc = 0, acc_cyc = 0, rise_cyc = 0;
  int          fd_cnt = 0, gaps = 0;
  logic        a_acc = 1'b0, chk_latch_lo = 1'b0;
  logic        d_prev = 1'b0, last_bit = 1'b0, have_bit = 1'b0, fd_prev = 1'b0;
  int          hi_len = 0, lo_len = 0, bit_idx = 0;
  logic [23:0] cur = '0;
  logic        b_prev = 1'b0;
  int          b_hi = 0, b_lo = 0, b_bits = 0, b_fd_cnt = 0;

  // One clock: advance, then sample and update decoders and the level model.
  task automatic step();
    logic acc, rst_edge, pop_seen;
    int   lo_exp;
    acc      = a_valid && a_ready && rst_n;
    rst_edge = !rst_n;
    @(posedge clk);
    #1;
    cyc++;
    a_acc    = acc;
    pop_seen = 1'b0;
    if (rst_edge) begin
      exp_q.delete();
      rx_q.delete();
      exp_level = 0;
      d_prev = 1'b0; have_bit = 1'b0; fd_prev = 1'b0;
      hi_len = 0; lo_len = 0; bit_idx = 0;
      b_prev = 1'b0; b_hi = 0; b_lo = 0;
    end else begin
      if (acc) begin
        exp_q.push_back(a_data);
        acc_cyc = cyc;
      end
      if (a_sdi && !d_prev) begin
        if (have_bit) begin
          lo_exp = last_bit ? T1L : T0L;
          if (bit_idx != 0) check("lo_len", lo_len, lo_exp);
          else if (lo_len > lo_exp) gaps++;
          else check("lo_len_pix", lo_len, lo_exp);
        end
        if (bit_idx == 0) begin
          pop_seen = 1'b1;
          rise_cyc = cyc;
        end
        hi_len = 1;
      end else if (a_sdi) begin
        hi_len++;
      end
      if (!a_sdi && d_prev) begin
        last_bit = (hi_len * 2 > T0H + T1H);
        check("hi_len", hi_len, last_bit ? T1H : T0H);
        cur      = {cur[22:0], last_bit};
        have_bit = 1'b1;
        bit_idx++;
        if (bit_idx == 24) begin
          rx_q.push_back(cur);
          bit_idx = 0;
        end
        lo_len = 1;
      end else if (!a_sdi) begin
        lo_len++;
      end
      d_prev    = a_sdi;
      exp_level = exp_level + int'(acc) - int'(pop_seen);
      if (exp_level > max_level) max_level = exp_level;
      check("level", a_level, exp_level);
      check("s_ready", a_ready, exp_level != 4);
      if (fd_prev) begin
        check("fd_width", a_fd, 0);
        check("busy_after_fd", a_busy, 0);
      end
      if (a_fd) begin
        fd_cnt++;
        check("busy_at_fd", a_busy, 1);
        if (chk_latch_lo) check("latch_lo", lo_len, (last_bit ? T1L : T0L) + 1 + RstC);
      end
      fd_prev = a_fd;

      if (b_sdi && !b_prev) begin
        if (b_bits % 32 != 0) check("b_lo", b_lo, T1L);
        b_hi = 1;
      end else if (b_sdi) begin
        b_hi++;
      end
      if (!b_sdi && b_prev) begin
        check("b_hi", b_hi, T1H);
        b_bits++;
        b_lo = 1;
      end else if (!b_sdi) begin
        b_lo++;
      end
      if (b_fd) begin
        b_fd_cnt++;
        check("b_latch_lo", b_lo, T1L + 1 + RstC);
      end
      b_prev = b_sdi;
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    gaps = 0; max_level = 0; chk_latch_lo = 1'b0;
    b_bits = 0; b_fd_cnt = 0;
    step();
  endtask

  task automatic push_a(input logic [23:0] d);
    int n;
    n       = 0;
    a_valid = 1'b1;
    a_data  = d;
    a_acc   = 1'b0;
    while (!a_acc && n < 3000) begin
      step();
      n++;
    end
    if (!a_acc) check("push_timeout", 0, 1);
    a_valid = 1'b0;
  endtask

  task automatic pulse_latch_a();
    a_latch = 1'b1;
    step();
    a_latch = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k;
    k = 0;
    while (rx_q.size() < n && k < budget) begin
      step();
      k++;
    end
    if (rx_q.size() < n) check("rx_timeout", rx_q.size(), n);
  endtask

  task automatic wait_fd(input int budget);
    int k, fd0;
    k   = 0;
    fd0 = fd_cnt;
    while (fd_cnt == fd0 && k < budget) begin
      step();
      k++;
    end
    if (fd_cnt == fd0) check("fd_timeout", 0, 1);
  endtask

  task automatic compare_rx(input string tag);
    check({tag, "_npix"}, rx_q.size(), exp_q.size());
    while (rx_q.size() > 0 && exp_q.size() > 0) check(tag, rx_q.pop_front(), exp_q.pop_front());
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int k, n, fd0;

    // Reset values
    rst_n = 1'b0;
    repeat (3) step();
    check("rst_ready", a_ready, 1);
    check("rst_busy", a_busy, 0);
    check("rst_fd", a_fd, 0);
    check("rst_ur", a_ur, 0);
    check("rst_level", a_level, 0);
    check("rst_sdi", a_sdi, 0);
    check("rst_b_state", {b_ready, b_busy, b_level, b_sdi}, 6'b100000);
    rst_n = 1'b1;
    step();

    // Single 0x800000 into an idle block
    push_a(24'h800000);
    wait_rx(1, 2000);
    check("latency", rise_cyc - acc_cyc + 1, 2);
    compare_rx("pix_800000");
    repeat (12) step();
    check("idle_busy", a_busy, 0);
    check("lone_ur", a_ur, 1);

    // Three back-to-back pixels then latch
    reset_dut();
    for (int i = 0; i < 3; i++) push_a(24'($urandom));
    pulse_latch_a();
    chk_latch_lo = 1'b1;
    fd0 = fd_cnt;
    wait_fd(5000);
    repeat (3) step();
    check("b2b_fd_count", fd_cnt - fd0, 1);
    check("b2b_gaps", gaps, 0);
    check("b2b_ur", a_ur, 0);
    compare_rx("b2b");

    // Fill the FIFO while shifting
    reset_dut();
    for (int i = 0; i < 10; i++) push_a(24'($urandom));
    pulse_latch_a();
    chk_latch_lo = 1'b1;
    wait_fd(10000);
    repeat (2) step();
    check("fill_peak", max_level, 4);
    check("fill_gaps", gaps, 0);
    compare_rx("fill");

    // Starvation between two pixels
    reset_dut();
    push_a(24'($urandom));
    repeat (30) step();
    check("ur_mid_pixel", a_ur, 0);
    wait_rx(1, 2000);
    repeat (100) step();
    check("ur_after_gap", a_ur, 1);
    push_a(24'($urandom));
    pulse_latch_a();
    chk_latch_lo = 1'b1;
    wait_fd(5000);
    step();
    check("ur_after_latch", a_ur, 1);
    compare_rx("underrun");

    // 32-bit instance: all ones, triple latch request
    reset_dut();
    b_data  = 32'hFFFF_FFFF;
    b_valid = 1'b1;
    step();
    b_valid = 1'b0;
    repeat (50) step();
    for (int i = 0; i < 3; i++) begin
      b_latch = 1'b1;
      step();
      b_latch = 1'b0;
      repeat (40) step();
    end
    k = 0;
    while (b_fd_cnt == 0 && k < 5000) begin
      step();
      k++;
    end
    repeat (900) step();
    check("b_fd_count", b_fd_cnt, 1);
    check("b_bits", b_bits, 32);
    check("b_ur", b_ur, 0);
    check("b_busy_end", b_busy, 0);

    // Reset in the middle of a HIGH phase
    reset_dut();
    for (int i = 0; i < 3; i++) push_a(24'($urandom));
    k = 0;
    while (!(a_sdi && hi_len == 2) && k < 500) begin
      step();
      k++;
    end
    rst_n = 1'b0;
    step();
    check("midrst_sdi", a_sdi, 0);
    check("midrst_level", a_level, 0);
    check("midrst_busy", a_busy, 0);
    rst_n = 1'b1;
    step();
    push_a(24'($urandom));
    wait_rx(1, 2000);
    check("midrst_latency", rise_cyc - acc_cyc + 1, 2);
    compare_rx("midrst");

    // Random frames with random push spacing
    chk_latch_lo = 1'b0;
    for (int f = 0; f < 4; f++) begin
      n = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 3)) step();
        push_a(24'($urandom));
      end
      pulse_latch_a();
      fd0 = fd_cnt;
      wait_fd(10000);
      repeat (2) step();
      check("rand_fd_count", fd_cnt - fd0, 1);
      compare_rx("rand_frame");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
